mem_access_ctrl: RTL and testbench

Initiator side of the multi-cycle RISC-V data-memory interface. Accepts one load/store request at a time from the core controller and issues word-aligned A/WD/WE accesses to the byte-addressed, little-endian DataMemory. The memory has a combinational word read and a posedge full-word write. Sub-word stores are done by read-modify-write; sub-word loads are extracted and extended here.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/lsu_align.sv | 77 +++++++
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 tb/tb_mem_access_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants and state encoding for the data-memory access controller.
package mem_access_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Clears the byte offset so the memory always sees a word address
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, store merge and request checks.
module lsu_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic              is_store,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_word,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merge_word,
  output logic              misaligned,
  output logic              illegal
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte lanes of the merged store word: selected lanes take store data, the rest keep memory
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;

      // Decide whether this lane is overwritten and by which store byte
      always_comb begin
        lane_hit = 1'b0;
        lane_src = store_data[8*gi +: 8];
        case (funct3[1:0])
          2'b00: begin
            lane_hit = (addr_lo == 2'(gi));
            lane_src = store_data[7:0];
          end
          2'b01: begin
            lane_hit = (addr_lo[1] == 1'(gi / 2));
            lane_src = store_data[8*(gi%2) +: 8];
          end
          2'b10: lane_hit = 1'b1;
          default: lane_hit = 1'b0;
        endcase
      end

      assign merge_word[8*gi +: 8] = lane_hit ? lane_src : mem_word[8*gi +: 8];
    end
  endgenerate

  // Pick the addressed byte/halfword and extend it for the load result
  always_comb begin
    byte_v   = mem_word[8*addr_lo +: 8];
    half_v   = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_val = {{16{half_v[15]}}, half_v};
      F3_W:    load_val = mem_word;
      F3_BU:   load_val = {24'd0, byte_v};
      F3_HU:   load_val = {16'd0, half_v};
      default: load_val = '0;
    endcase
  end

  // Flag encodings that do not exist and accesses that straddle their natural boundary
  always_comb begin
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (is_store && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store initiator toward a word-wide, byte-addressed data memory.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        funct3_reg;
  logic              store_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] merge_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [2:0]        al_funct3;
  logic              al_store;
  logic [1:0]        al_addr_lo;
  logic [DATA_W-1:0] al_word;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_word;
  logic              misaligned;
  logic              illegal;

  // In IDLE the checks must see the incoming request so an error needs no extra cycle;
  // afterwards the latched request drives the lane logic.
  assign al_funct3  = (state_reg == S_IDLE) ? funct3   : funct3_reg;
  assign al_store   = (state_reg == S_IDLE) ? is_store : store_reg;
  assign al_addr_lo = (state_reg == S_IDLE) ? addr[1:0] : addr_reg[1:0];
  // Loads extract from the live read word; sub-word stores merge into the latched copy
  assign al_word    = (state_reg == S_READ) ? mem_RD : merge_reg;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (al_funct3),
    .is_store   (al_store),
    .addr_lo    (al_addr_lo),
    .mem_word   (al_word),
    .store_data (wdata_reg),
    .load_val   (load_val),
    .merge_word (merge_word),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // State register and request/data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      addr_reg   <= '0;
      funct3_reg <= '0;
      store_reg  <= 1'b0;
      wdata_reg  <= '0;
      merge_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && req) begin
        addr_reg   <= addr;
        funct3_reg <= funct3;
        store_reg  <= is_store;
        wdata_reg  <= wdata;
      end
      if (state_reg == S_READ) begin
        if (store_reg) merge_reg <= mem_RD;
        else           rdata_reg <= load_val;
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (illegal || misaligned)         state_next = S_ERR;
          else if (is_store && funct3 == F3_W) state_next = S_WRITE;
          else                                 state_next = S_READ;
        end
      end
      S_READ:  state_next = store_reg ? S_WRITE : S_DONE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy   = (state_reg != S_IDLE);
  assign done   = (state_reg == S_DONE) || (state_reg == S_ERR);
  assign err    = (state_reg == S_ERR);
  assign rdata  = rdata_reg;
  assign mem_A  = addr_reg & WORD_ALIGN_MASK[ADDR_W-1:0];
  assign mem_WE = (state_reg == S_WRITE);
  assign mem_WD = (state_reg == S_WRITE) ? merge_word : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a small word-addressed memory model.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk, rst, req, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_A, mem_WD, mem_RD;
  logic        busy, done, err, mem_WE;

  logic [31:0] mem [0:255];

  typedef struct {
    int          done_cyc;
    logic        err;
    logic [31:0] rdata;
    int          we;
    logic [31:0] wa;
    logic [31:0] wd;
    string       nm;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, we_cnt = 0, done_cnt = 0, issued = 0;
  logic [31:0] last_rd = 32'h0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, posedge full-word write
  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: checks write beats against the head expectation and retires it on done
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_WE && sbq.size() > 0) begin
        we_cnt++;
        chk({sbq[0].nm, " mem_A"}, mem_A, sbq[0].wa);
        chk({sbq[0].nm, " mem_WD"}, mem_WD, sbq[0].wd);
      end
      if (done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.nm, " err"}, 32'(err), 32'(e.err));
          chk({e.nm, " rdata"}, rdata, e.rdata);
          chk({e.nm, " done_cycle"}, 32'(cyc), 32'(e.done_cyc));
          chk({e.nm, " we_pulses"}, 32'(we_cnt), 32'(e.we));
          $display("txn %-12s err=%0b rdata=%08h cyc=%0d we=%0d", e.nm, err, rdata, cyc, we_cnt);
        end
        we_cnt = 0;
      end
    end
  end

  // Present one request at the first idle cycle; hold keeps req high afterwards
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input int e_we, input logic [31:0] e_wd, input int lat,
                       input string nm, input bit hold);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s idle_wait: busy stuck high, expected idle within 50 cycles", nm);
    end
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    e.done_cyc = cyc + lat; e.err = e_err; e.rdata = e_rd; e.we = e_we;
    e.wa = a & 32'hFFFF_FFFC; e.wd = e_wd; e.nm = nm;
    sbq.push_back(e);
    issued++;
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_v,
                    input string nm, input bit hold);
    last_rd = exp_v;
    issue(1'b0, f3, a, 32'h0, 1'b0, exp_v, 0, 32'h0, 2, nm, hold);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_word, input string nm, input bit hold);
    issue(1'b1, f3, a, wd, 1'b0, last_rd, 1, exp_word, (f3 == F3_W) ? 2 : 3, nm, hold);
  endtask

  task automatic bad(input logic s, input logic [2:0] f3, input logic [31:0] a, input string nm);
    issue(s, f3, a, 32'hFFFF_FFFF, 1'b1, last_rd, 0, 32'h0, 1, nm, 1'b0);
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while ((sbq.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, " drain"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic chk_idle(input string p);
    chk({p, " busy"}, 32'(busy), 32'd0);
    chk({p, " done"}, 32'(done), 32'd0);
    chk({p, " err"}, 32'(err), 32'd0);
    chk({p, " rdata"}, rdata, 32'd0);
    chk({p, " mem_A"}, mem_A, 32'd0);
    chk({p, " mem_WD"}, mem_WD, 32'd0);
    chk({p, " mem_WE"}, 32'(mem_WE), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h8899AABB;
    rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");

    // Sub-word and word loads from 0x8899AABB
    ld(F3_B,  32'h101, 32'hFFFFFFAA, "lb_101", 1'b0);
    ld(F3_BU, 32'h101, 32'h000000AA, "lbu_101", 1'b0);
    ld(F3_H,  32'h102, 32'hFFFF8899, "lh_102", 1'b0);
    ld(F3_W,  32'h100, 32'h8899AABB, "lw_100", 1'b0);
    ld(F3_HU, 32'h102, 32'h00008899, "lhu_102", 1'b0);
    ld(F3_H,  32'h100, 32'hFFFFAABB, "lh_100", 1'b0);
    ld(F3_B,  32'h103, 32'hFFFFFF88, "lb_103", 1'b0);

    // Word store, read-back, then read-modify-write stores
    st(F3_W, 32'h200, 32'h12345678, 32'h12345678, "sw_200", 1'b0);
    ld(F3_W, 32'h200, 32'h12345678, "lw_200", 1'b0);
    st(F3_B, 32'h203, 32'h000000EE, 32'hEE345678, "sb_203", 1'b0);
    st(F3_H, 32'h200, 32'h0000CAFE, 32'hEE34CAFE, "sh_200", 1'b0);
    drain("rmw");
    chk("mem_200", mem[32'h200 >> 2], 32'hEE34CAFE);
    ld(F3_W, 32'h200, 32'hEE34CAFE, "lw_200b", 1'b0);

    // Error requests: one-cycle ERR, no write, rdata held
    bad(1'b0, F3_W, 32'h102, "lw_mis");
    bad(1'b1, F3_H, 32'h101, "sh_mis");
    bad(1'b0, 3'b011, 32'h100, "f3_011");
    bad(1'b1, F3_BU, 32'h100, "sbu_ill");
    drain("err");
    chk("mem_100_after_err", mem[32'h100 >> 2], 32'h8899AABB);

    // req held high across alternating loads and stores
    ld(F3_W,  32'h100, 32'h8899AABB, "b2b_lw", 1'b1);
    st(F3_B,  32'h101, 32'h00000055, 32'h889955BB, "b2b_sb", 1'b1);
    ld(F3_BU, 32'h101, 32'h00000055, "b2b_lbu", 1'b1);
    st(F3_W,  32'h204, 32'hDEADBEEF, 32'hDEADBEEF, "b2b_sw", 1'b1);
    ld(F3_W,  32'h204, 32'hDEADBEEF, "b2b_lw2", 1'b1);
    st(F3_H,  32'h206, 32'h00001234, 32'h1234BEEF, "b2b_sh", 1'b0);
    drain("b2b");
    chk("b2b done_count", 32'(done_cnt), 32'(issued));
    chk("mem_204", mem[32'h204 >> 2], 32'h1234BEEF);

    // Reset during the READ of an sb: no write may happen
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = F3_B; addr = 32'h208; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_in_read");
    @(negedge clk);
    chk("mem_208_unchanged", mem[32'h208 >> 2], 32'h0);
    $display("txn %-12s reset during READ, mem[208]=%08h", "rst_sb", mem[32'h208 >> 2]);

    // Reset during the WRITE of an sw: the write still lands at that edge
    req = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h20C; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rst_sw mem_WE", 32'(mem_WE), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0;
    chk_idle("rst_in_write");
    chk("mem_20C_written", mem[32'h20C >> 2], 32'hA5A5A5A5);
    $display("txn %-12s reset during WRITE, mem[20C]=%08h", "rst_sw", mem[32'h20C >> 2]);

    repeat (2) @(negedge clk);
    chk("final done_count", 32'(done_cnt), 32'(issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
